i2c_txn_arbiter: RTL and testbench

//  Shares one I2C bus master (i2c_controller) between NREQ local requesters.

---
 rtl/i2c_arb_pkg.sv | 20 ++
 rtl/i2c_txn_arbiter_rr_picker.sv | 33 +++
 rtl/i2c_txn_arbiter.sv | 156 +++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared state encoding, default widths and sizing helper for the I2C
// transaction arbiter.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 32;

  // Bits needed for a counter that must reach timeout_cyc-1.
  function automatic int cnt_width(input int timeout_cyc);
    return $clog2(timeout_cyc);
  endfunction

endpackage

// File: rtl/i2c_txn_arbiter_rr_picker.sv
// Combinational round-robin picker: first active request at or after ptr,
// wrapping, reported both one-hot and as an index.
module rr_picker #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  winner,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan NREQ slots starting at ptr and keep only the first hit.
  always_comb begin
    int j;
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j] && !found) begin
        found     = 1'b1;
        winner[j] = 1'b1;
        idx       = IDX_W'(j);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master between NREQ requesters; owns
// the enable/ready handshake, per-phase timeout and result return.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0]        req_rw,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [NREQ-1:0]        err,
  output logic [DATA_W-1:0]      rdata,
  output logic                   m_enable,
  output logic [ADDR_W-1:0]      m_addr,
  output logic                   m_rw,
  output logic [DATA_W-1:0]      m_wdata,
  input  logic [DATA_W-1:0]      m_rdata,
  input  logic                   m_ready
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);

  arb_state_t       state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] owner_r;
  logic [CNT_W-1:0] cnt_r;
  logic [NREQ-1:0]  pick_onehot_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_found_s;
  logic [IDX_W-1:0] next_ptr_s;
  logic             timeout_s;

  rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req    (req),
    .ptr    (ptr_r),
    .winner (pick_onehot_s),
    .idx    (pick_idx_s),
    .found  (pick_found_s)
  );

  // Pointer lands one past the current owner, wrapping at NREQ.
  always_comb begin
    if (owner_r == IDX_LAST) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = owner_r + IDX_ONE;
    end
  end

  // Timeout fires on the last allowed cycle of a handshake phase.
  always_comb begin
    if (cnt_r == CNT_LAST) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Transaction FSM with latched request fields and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IDLE;
      ptr_r    <= '0;
      owner_r  <= '0;
      cnt_r    <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= '0;
      rdata    <= '0;
      m_enable <= 1'b0;
      m_addr   <= '0;
      m_rw     <= 1'b0;
      m_wdata  <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state_r)
        IDLE: begin
          // A busy bus (m_ready low) means someone else owns it: hold off.
          if (m_ready && pick_found_s) begin
            owner_r  <= pick_idx_s;
            gnt      <= pick_onehot_s;
            m_addr   <= req_addr[int'(pick_idx_s)*ADDR_W +: ADDR_W];
            m_rw     <= req_rw[pick_idx_s];
            m_wdata  <= req_wdata[int'(pick_idx_s)*DATA_W +: DATA_W];
            m_enable <= 1'b1;
            state_r  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_r   <= '0;
          state_r <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!m_ready) begin
            m_enable <= 1'b0;
            cnt_r    <= '0;
            state_r  <= WAIT_DONE;
          end else if (timeout_s) begin
            done     <= gnt;
            err      <= gnt;
            gnt      <= '0;
            m_enable <= 1'b0;
            ptr_r    <= next_ptr_s;
            state_r  <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        WAIT_DONE: begin
          // Completion wins over a timeout landing in the same cycle.
          if (m_ready) begin
            if (m_rw) begin
              rdata <= m_rdata;
            end
            done    <= gnt;
            gnt     <= '0;
            ptr_r   <= next_ptr_s;
            state_r <= IDLE;
          end else if (timeout_s) begin
            done     <= gnt;
            err      <= gnt;
            gnt      <= '0;
            m_enable <= 1'b0;
            ptr_r    <= next_ptr_s;
            state_r  <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          gnt      <= '0;
          m_enable <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench: a round-robin service-order model predicts each
// transaction's grant and result; a monitor compares what the DUT presents.
module tb_i2c_txn_arbiter;

  localparam int NREQ   = 2;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int TOUT   = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_rw;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        gnt, done, err;
  logic [DATA_W-1:0]      rdata;
  logic                   m_enable;
  logic [ADDR_W-1:0]      m_addr;
  logic                   m_rw;
  logic [DATA_W-1:0]      m_wdata;
  logic [DATA_W-1:0]      m_rdata;
  logic                   m_ready;

  always #5 clk = ~clk;

  i2c_txn_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .m_enable(m_enable), .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  typedef struct {
    logic [6:0]  addr;
    logic        rw;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int          idx;
    logic [6:0]  addr;
    logic        rw;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  txn_t        rq [NREQ][$];
  exp_t        exp_q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          model_ptr = 0;
  logic [31:0] model_rdata = 32'h0;
  int          cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cycle);
    end
  endtask

  // Slave behaviour: 7'h7F never answers; known addresses return fixed data.
  function automatic logic [31:0] rd_value(input logic [6:0] a);
    if (a == 7'h50) return 32'hDEADBEEF;
    if (a == 7'h34) return 32'h0000_1234;
    return {a, a, a, a, 4'h9};
  endfunction

  function automatic int busy_len(input logic [6:0] a);
    if (a == 7'h50) return 20;
    if (a == 7'h66) return 25;
    return 1 + (int'(a) % 13);
  endfunction

  // Master model: drops ready two cycles after enable, raises it after busy.
  initial begin : master
    int st, cnt;
    logic [6:0] a;
    st = 0; cnt = 0; a = 7'h0;
    m_ready = 1'b1;
    m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      case (st)
        0: if (m_enable && m_ready && m_addr != 7'h7F) begin
             a = m_addr; cnt = 2; st = 1;
           end
        1: begin
             cnt--;
             if (cnt == 0) begin m_ready = 1'b0; cnt = busy_len(a); st = 2; end
           end
        2: begin
             cnt--;
             if (cnt == 0) begin m_rdata = rd_value(a); m_ready = 1'b1; st = 0; end
           end
        default: st = 0;
      endcase
    end
  end

  // Monitor: check grant fields when gnt rises, results when done/err pulse.
  initial begin : monitor
    logic [NREQ-1:0] prev_gnt;
    int gcyc;
    exp_t e;
    prev_gnt = '0; gcyc = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_gnt = '0;
      end else begin
        if (gnt != '0 && prev_gnt == '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_gnt", 64'(gnt), 64'h0);
          end else begin
            e = exp_q[0];
            check("gnt", 64'(gnt), 64'd1 << e.idx);
            check("m_addr", 64'(m_addr), 64'(e.addr));
            check("m_rw", 64'(m_rw), 64'(e.rw));
            check("m_wdata", 64'(m_wdata), 64'(e.wdata));
            check("m_enable_issue", 64'(m_enable), 64'h1);
            gcyc = cycle;
          end
        end
        if (done != '0 || err != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(done), 64'h0);
          end else begin
            e = exp_q.pop_front();
            check("done", 64'(done), 64'd1 << e.idx);
            check("err", 64'(err), e.err ? (64'd1 << e.idx) : 64'h0);
            check("rdata", 64'(rdata), 64'(e.rdata));
            check("gnt_clear", 64'(gnt), 64'h0);
            check("m_enable_low", 64'(m_enable), 64'h0);
            if (e.err) check("timeout_latency", 64'(cycle - gcyc), 64'(TOUT + 1));
          end
        end
        prev_gnt = gnt;
      end
    end
  end

  task automatic load_slot(input int i, input txn_t t);
    req_addr[i*ADDR_W +: ADDR_W]  = t.addr;
    req_rw[i]                     = t.rw;
    req_wdata[i*DATA_W +: DATA_W] = t.wdata;
  endtask

  // Reference: serve pending per-requester queues in round-robin order.
  task automatic start_phase();
    int pos[NREQ];
    int total, ptr, j, c;
    txn_t t;
    exp_t e;
    total = 0;
    for (int i = 0; i < NREQ; i++) begin pos[i] = 0; total += rq[i].size(); end
    ptr = model_ptr;
    for (int n = 0; n < total; n++) begin
      j = -1;
      for (int k = 0; k < NREQ; k++) begin
        c = (ptr + k) % NREQ;
        if (j < 0 && pos[c] < rq[c].size()) j = c;
      end
      t = rq[j][pos[j]];
      pos[j]++;
      e.idx = j; e.addr = t.addr; e.rw = t.rw; e.wdata = t.wdata;
      e.err = (t.addr == 7'h7F);
      if (!e.err && t.rw) model_rdata = rd_value(t.addr);
      e.rdata = model_rdata;
      exp_q.push_back(e);
      ptr = (j + 1) % NREQ;
    end
    model_ptr = ptr;
    for (int i = 0; i < NREQ; i++)
      if (rq[i].size() > 0) begin load_slot(i, rq[i][0]); req[i] = 1'b1; end
  endtask

  // Requesters keep req high while work remains and reload data on done.
  task automatic wait_phase(input int budget);
    int n;
    bit busy;
    n = 0; busy = 1'b1;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) begin
          if (rq[i].size() > 0) void'(rq[i].pop_front());
          if (rq[i].size() > 0) load_slot(i, rq[i][0]);
          else req[i] = 1'b0;
        end
      end
      busy = (exp_q.size() > 0);
      for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) busy = 1'b1;
    end
    if (busy) begin
      compared++; mismatched++;
      $display("FAIL phase_timeout: %0d results still pending after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
      for (int i = 0; i < NREQ; i++) rq[i].delete();
      req = '0;
    end
  endtask

  function automatic txn_t mk(input logic [6:0] a, input logic rw, input logic [31:0] wd);
    txn_t t;
    t.addr = a; t.rw = rw; t.wdata = wd;
    return t;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 64'(gnt), 64'h0);
    check({tag, "_done"}, 64'(done), 64'h0);
    check({tag, "_err"}, 64'(err), 64'h0);
    check({tag, "_m_enable"}, 64'(m_enable), 64'h0);
    check({tag, "_m_addr"}, 64'(m_addr), 64'h0);
    check({tag, "_m_wdata"}, 64'(m_wdata), 64'h0);
    check({tag, "_rdata"}, 64'(rdata), 64'h0);
  endtask

  initial begin : stimulus
    int waited, cnt;
    logic [6:0] a;
    rst = 1'b0; req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;

    // Reset with both requests up: nothing may be granted while held.
    rq[0].push_back(mk(7'h11, 1'b0, $urandom));
    rq[1].push_back(mk(7'h22, 1'b1, $urandom));
    start_phase();
    for (int i = 0; i < 3; i++) begin @(negedge clk); check_all_zero("reset"); end
    rst = 1'b1;
    wait_phase(2000);

    // Single read returning known data.
    rq[0].push_back(mk(7'h50, 1'b1, $urandom));
    start_phase();
    wait_phase(2000);
    check("read_rdata", 64'(rdata), 64'h0000_0000_DEAD_BEEF);

    // Contention: both requesters with two transactions each.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++)
        rq[i].push_back(mk(7'($urandom_range(0, 125)), 1'($urandom), $urandom));
    start_phase();
    wait_phase(2000);

    // Timeout: slave never drops ready.
    rq[1].push_back(mk(7'h7F, 1'b1, $urandom));
    start_phase();
    wait_phase(2000);
    check("m_enable_after_timeout", 64'(m_enable), 64'h0);

    // Reset while waiting for completion.
    rq[0].push_back(mk(7'h66, 1'b1, $urandom));
    start_phase();
    waited = 0;
    do begin @(negedge clk); waited++; end
    while (!(gnt[0] && !m_enable && !m_ready) && waited < 100);
    if (waited >= 100) check("reach_wait_done", 64'(waited), 64'h0);
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    exp_q.delete();
    model_ptr = 0; model_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin @(negedge clk); check_all_zero("midop_reset"); end
    rst = 1'b1;
    rq[1].push_back(mk(7'h21, 1'b1, $urandom));
    start_phase();
    wait_phase(2000);

    // Write after a read leaves rdata untouched.
    rq[1].push_back(mk(7'h34, 1'b1, $urandom));
    rq[1].push_back(mk(7'h40, 1'b0, 32'hCAFE_F00D));
    start_phase();
    wait_phase(2000);
    check("write_keeps_rdata", 64'(rdata), 64'h0000_0000_0000_1234);

    // Randomized phases, occasionally with a non-responding slave.
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt = $urandom_range(0, 3);
        for (int k = 0; k < cnt; k++) begin
          a = ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom_range(0, 125));
          rq[i].push_back(mk(a, 1'($urandom), $urandom));
        end
      end
      if (rq[0].size() == 0 && rq[1].size() == 0)
        rq[0].push_back(mk(7'h50, 1'b1, $urandom));
      start_phase();
      wait_phase(3000);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
